// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_seq
//  Description : Iterative RV32M divide/remainder sequencer that sits in the
//                execute stage. It uses a one-bit-per-cycle restoring divide
//                and holds the pipeline through `busy`. `done` pulses for one
//                cycle together with the registered `result`.
//                Optional shift-add multiply is enabled with MULDIV_MUL_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module muldiv_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    localparam logic [1:0]  c_IDLE     = 2'd0;
    localparam logic [1:0]  c_CALC     = 2'd1;
    localparam logic [1:0]  c_DONE     = 2'd2;
    localparam logic [4:0]  c_LAST_CNT = 5'd31;
    localparam logic [31:0] c_INT_MIN  = 32'h8000_0000;
    localparam logic [31:0] c_ALL_ONES = 32'hFFFF_FFFF;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [4:0]  r_cnt;
    // Divide: {remainder, quotient}. Multiply: {product high, multiplier/product low}.
    logic [63:0] r_shreg;
    // Divisor magnitude (divide) or multiplicand magnitude (multiply).
    logic [31:0] r_operand;
    logic        r_is_rem;
    logic        r_neg_q;      // negate quotient / product at the end
    logic        r_neg_r;      // remainder takes the dividend's sign
`ifdef MULDIV_MUL_EN
    logic        r_is_mul;
    logic        r_is_mullo;
`endif

    // Operand decode for the issue cycle
    logic        w_accept;
    logic        w_a_sgn;
    logic        w_b_sgn;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic        w_div_zero;
    logic        w_div_ovf;
    logic        w_fast;
    logic [31:0] w_fast_res;

    // Iteration datapath
    logic [32:0] w_rem_ext;
    logic        w_ge;
    logic [63:0] w_div_next;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;
    logic [31:0] w_div_res;
    logic [63:0] w_step;
    logic [31:0] w_calc_res;
`ifdef MULDIV_MUL_EN
    logic [32:0] w_sum;
    logic [63:0] w_mul_next;
    logic [63:0] w_prod;
    logic [31:0] w_mul_res;
`endif

    assign w_accept = (r_state == c_IDLE) && start && !flush;

    // Signedness per funct3: DIV/REM sign both; MULH both; MULHSU only srcA.
    assign w_a_sgn = op[2] ? !op[0] : ((op[1:0] == 2'b01) || (op[1:0] == 2'b10));
    assign w_b_sgn = op[2] ? !op[0] : (op[1:0] == 2'b01);
    assign w_a_neg = w_a_sgn && srcA[31];
    assign w_b_neg = w_b_sgn && srcB[31];
    assign w_a_mag = w_a_neg ? (~srcA + 32'd1) : srcA;
    assign w_b_mag = w_b_neg ? (~srcB + 32'd1) : srcB;

    // Cases that finish without iterating
    assign w_div_zero = op[2] && (srcB == 32'd0);
    assign w_div_ovf  = op[2] && !op[0] && (srcA == c_INT_MIN) && (srcB == c_ALL_ONES);
`ifdef MULDIV_MUL_EN
    assign w_fast = w_div_zero || w_div_ovf;
`else
    // Without the multiplier every multiply op completes immediately with zero.
    assign w_fast = !op[2] || w_div_zero || w_div_ovf;
`endif

    // Immediate result for the fast paths; op[1] selects remainder over quotient
    always_comb begin
        w_fast_res = 32'd0;
        if (op[2]) begin
            if (w_div_zero) begin
                w_fast_res = op[1] ? srcA : c_ALL_ONES;
            end else if (w_div_ovf) begin
                w_fast_res = op[1] ? 32'd0 : c_INT_MIN;
            end
        end
    end

    // Restoring divide step: the shifted-out remainder bit is kept so a
    // divisor of 2^31 or more compares correctly.
    assign w_rem_ext  = r_shreg[63:31];
    assign w_ge       = (w_rem_ext >= {1'b0, r_operand});
    assign w_div_next = w_ge ? {w_rem_ext[31:0] - r_operand, r_shreg[30:0], 1'b1}
                             : {r_shreg[62:0], 1'b0};
    assign w_quo_fix  = r_neg_q ? (~w_div_next[31:0] + 32'd1)  : w_div_next[31:0];
    assign w_rem_fix  = r_neg_r ? (~w_div_next[63:32] + 32'd1) : w_div_next[63:32];
    assign w_div_res  = r_is_rem ? w_rem_fix : w_quo_fix;

`ifdef MULDIV_MUL_EN
    // Shift-add step: add multiplicand when multiplier LSB is set, shift right.
    assign w_sum      = {1'b0, r_shreg[63:32]} + {1'b0, (r_shreg[0] ? r_operand : 32'd0)};
    assign w_mul_next = {w_sum, r_shreg[31:1]};
    assign w_prod     = r_neg_q ? (~w_mul_next + 64'd1) : w_mul_next;
    assign w_mul_res  = r_is_mullo ? w_prod[31:0] : w_prod[63:32];
    assign w_step     = r_is_mul ? w_mul_next : w_div_next;
    assign w_calc_res = r_is_mul ? w_mul_res  : w_div_res;
`else
    assign w_step     = w_div_next;
    assign w_calc_res = w_div_res;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: flush beats start in IDLE and aborts CALC
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_next_state = w_fast ? c_DONE : c_CALC;
                end
            end
            c_CALC: begin
                if (flush) begin
                    w_next_state = c_IDLE;
                end else if (r_cnt == c_LAST_CNT) begin
                    w_next_state = c_DONE;
                end
            end
            c_DONE: begin
                // Same instruction still sits in execute; start is ignored.
                w_next_state = c_IDLE;
            end
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
    end

    // Outputs: busy stalls in the issue cycle and through CALC, drops in DONE
    always_comb begin
        busy = w_accept || (r_state == c_CALC);
        done = (r_state == c_DONE);
    end

    // Datapath: latch operands on issue, iterate in CALC, load result on entry to DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= 5'd0;
            r_shreg   <= 64'd0;
            r_operand <= 32'd0;
            r_is_rem  <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            result    <= 32'd0;
`ifdef MULDIV_MUL_EN
            r_is_mul   <= 1'b0;
            r_is_mullo <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_cnt    <= 5'd0;
                        r_is_rem <= op[1];
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
`ifdef MULDIV_MUL_EN
                        r_is_mul   <= !op[2];
                        r_is_mullo <= (op[1:0] == 2'b00);
                        if (!op[2]) begin
                            r_operand <= w_a_mag;
                            r_shreg   <= {32'd0, w_b_mag};
                        end else begin
                            r_operand <= w_b_mag;
                            r_shreg   <= {32'd0, w_a_mag};
                        end
`else
                        r_operand <= w_b_mag;
                        r_shreg   <= {32'd0, w_a_mag};
`endif
                        if (w_fast) begin
                            result <= w_fast_res;
                        end
                    end
                end
                c_CALC: begin
                    if (!flush) begin
                        r_shreg <= w_step;
                        r_cnt   <= r_cnt + 5'd1;
                        if (r_cnt == c_LAST_CNT) begin
                            result <= w_calc_res;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_seq
//  Description : Scoreboard bench for muldiv_seq. Expected results and done
//                cycles are queued at issue and checked when done pulses.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_muldiv_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } sb_t;

    sb_t         sb[$];
    int          cyc;
    int          n_tests;
    int          n_fail;
    logic [31:0] last_res;

    muldiv_seq dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .srcA   (srcA),
        .srcB   (srcB),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index: value seen after a rising edge names the cycle that follows it
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest queued expectation
    always @(negedge clk) begin
        sb_t e;
        if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("result", result, e.res);
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
                last_res = e.res;
            end
        end
    end

    // Issue one op, count busy cycles, wait for done (bounded)
    task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp,
                         input bit fast, input bit hold);
        int  nb;
        bit  seen;
        sb_t e;
        @(posedge clk); #1;
        start = 1'b1; op = o; srcA = a; srcB = b;
        e.res = exp;
        e.cyc = cyc + (fast ? 1 : 33);
        sb.push_back(e);
        @(negedge clk);
        nb   = busy ? 1 : 0;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(posedge clk); #1;
            if (!hold) start = 1'b0;
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                chk({tag, "_busy_in_done"}, 32'(busy), 32'd0);
            end else if (busy) begin
                nb++;
            end
        end
        if (!seen) chk({tag, "_timeout"}, 32'd0, 32'd1);
        chk({tag, "_busy_cycles"}, 32'(nb), fast ? 32'd1 : 32'd33);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        cyc = 0; n_tests = 0; n_fail = 0; last_res = 32'd0;
        rst = 1'b1; start = 1'b0; op = 3'd0; srcA = 32'd0; srcB = 32'd0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", result, 32'd0);

        // Iterative divides
        do_op("divu",     3'b101, 32'd100,        32'd7,          32'd14,         0, 0);
        do_op("remu",     3'b111, 32'd100,        32'd7,          32'd2,          0, 0);
        do_op("div_neg",  3'b100, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  0, 0);
        do_op("rem_neg",  3'b110, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  0, 0);
        do_op("div_nb",   3'b100, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  0, 0);
        do_op("rem_nb",   3'b110, 32'd7,          32'hFFFF_FFFE,  32'd1,          0, 0);
        do_op("divu_big", 3'b101, 32'hFFFF_FFFF,  32'h8000_0001,  32'd1,          0, 0);
        do_op("remu_big", 3'b111, 32'hFFFF_FFFF,  32'h8000_0001,  32'h7FFF_FFFE,  0, 0);

        // Fast paths
        do_op("divu_z",   3'b101, 32'h1234,       32'd0,          32'hFFFF_FFFF,  1, 0);
        do_op("remu_z",   3'b111, 32'h1234,       32'd0,          32'h1234,       1, 0);
        do_op("rem_z",    3'b110, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  1, 0);
        do_op("div_ovf",  3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1, 0);
        do_op("rem_ovf",  3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1, 0);

`ifdef MULDIV_MUL_EN
        do_op("mulhu",    3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  0, 0);
        do_op("mul",      3'b000, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          0, 0);
        do_op("mulh",     3'b001, 32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  0, 0);
        do_op("mulhsu",   3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  0, 0);
`else
        do_op("mul_off",  3'b000, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          1, 0);
`endif

        // Give result a known nonzero value before the abort tests
        do_op("divu_pre", 3'b101, 32'd1000,       32'd3,          32'd333,        0, 0);

        // Flush at counter 10: no done, result held
        @(posedge clk); #1;
        start = 1'b1; op = 3'b101; srcA = 32'd50; srcB = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        chk("flush_busy_calc", 32'(busy), 32'd1);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_busy_after", 32'(busy), 32'd0);
        chk("flush_done_after", 32'(done), 32'd0);
        chk("flush_result_kept", result, last_res);
        do_op("after_flush", 3'b101, 32'd50, 32'd5, 32'd10, 0, 0);

        // start and flush together in IDLE: not accepted
        @(posedge clk); #1;
        start = 1'b1; flush = 1'b1; op = 3'b101; srcA = 32'd9; srcB = 32'd2;
        @(negedge clk);
        chk("start_flush_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("start_flush_idle", 32'(busy), 32'd0);

        // Reset in the middle of CALC
        @(posedge clk); #1;
        start = 1'b1; op = 3'b101; srcA = 32'd77; srcB = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_result", result, 32'd0);
        last_res = 32'd0;

        // start held through DONE must not restart
        do_op("hold", 3'b100, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 0, 1);

        repeat (5) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative RV32M divide/remainder sequencer (optional multiply) that sits beside the ALU in the execute stage of the five-stage pipeline. When an M-extension instruction reaches execute, it takes the forwarded operands and runs a one-bit-per-cycle restoring algorithm. Meanwhile it holds the pipeline via `busy`, which the hazard logic ORs into StallF/StallD and the execute-stage hold. It pulses `done` with `result` for one cycle so the execute→memory register captures the result.

## Interface
Parameters:
- none (width fixed at 32).

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  valid M-extension op in execute stage (already qualified by decode; not flushed).
- `op`  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `srcA`  in  32  forwarded rs1 value (dividend / multiplicand).
- `srcB`  in  32  forwarded rs2 value (divisor / multiplier).
- `flush`  in  1  execute-stage flush; aborts any operation in progress.
- `busy`  out  1  stall request to the hazard logic.
- `done`  out  1  one-cycle pulse; `result` valid this cycle.
- `result`  out  32  registered result, held until next `done`.

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - `start & ~flush` latches `op` and the operand magnitudes; signed ops use two's-complement abs.
  - Normal op → CALC with counter = 0.
  - Fast-path op → DONE directly.
- Fast paths (no CALC):
  - Divisor 0: quotient 32'hFFFFFFFF, remainder = srcA.
  - DIV/REM of 32'h80000000 by 32'hFFFFFFFF: quotient 32'h80000000, remainder 0.
- CALC, divide: 64-bit {rem,quo} shift register.
  - Each cycle, shift left 1 and trial-subtract the divisor from the upper half.
  - Set quotient LSB when no borrow; otherwise restore.
  - Counter 0..31; after counter=31 → DONE.
- Sign fix on entry to DONE:
  - Quotient is negated if the operand signs differ (DIV).
  - Remainder takes the dividend's sign (REM).
  - Unsigned ops are not adjusted.
- DONE: `done`=1, `result` registered. Always → IDLE next cycle; `start` is ignored in DONE because the same instruction is still in execute.
- `flush` in CALC → IDLE next cycle; no `done`; `result` unchanged.
- `busy` = (IDLE & `start` & ~`flush`) | CALC. It is combinational from `start` so the stall takes effect in the issue cycle. It is low in DONE, so the pipeline advances and captures `result`.
- `rst` in any state → IDLE, counter 0, shift register 0.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=32'h0.
- Normal op accepted in cycle N:
  - CALC cycles N+1..N+32.
  - DONE/`done` at N+33.
  - `busy` high N..N+32 (33 cycles).
- Fast path: `done` at N+1; `busy` high only in N.
- Back-to-back ops: second `start` is accepted at the earliest in IDLE at N+34 (normal) or N+2 (fast).
- `flush` and `start` in the same IDLE cycle: not accepted; `busy`=0.
- `rst` has priority over `flush`, which has priority over `start`.

## Configuration
- `MULDIV_MUL_EN` defined:
  - op[2]=0 runs 32-cycle shift-add on magnitudes, same timing as divide, no fast path.
  - Product is 64-bit. MULH negates if signs differ; MULHSU treats only srcA as signed.
  - MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32].
- Not defined: op[2]=0 takes the fast path with `result`=32'h0. No multiply datapath is synthesised.

## Test plan
- DIVU 100/7 at N → `busy` high N..N+32, `done` at N+33, `result`=14. REMU same operands → 2.
- DIV 32'hFFFFFFF9/2 → 32'hFFFFFFFD. REM same operands → 32'hFFFFFFFF. DIV 7/32'hFFFFFFFE → 32'hFFFFFFFD.
- Fast paths:
  - DIVU 32'h1234/0 → 32'hFFFFFFFF at N+1.
  - REMU 32'h1234/0 → 32'h1234.
  - DIV 32'h80000000/32'hFFFFFFFF → 32'h80000000.
  - REM same operands → 0.
- `flush` at CALC counter=10 → `busy` 0 next cycle, no `done`, `result` keeps its old value. A new `start` two cycles later completes normally.
- `rst` pulse mid-CALC → next cycle `busy`=0, `done`=0, `result`=0. `start` held high through DONE does not restart the operation.
- With `MULDIV_MUL_EN`: MULHU 32'hFFFFFFFF×32'hFFFFFFFF → 32'hFFFFFFFE, MUL same operands → 1, `done` at N+33. Without it: MUL → 0 at N+1.
